// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: data word, tag, CDB
// bundle, ALU opcode and the per-entry storage record.
package reservation_station_pkg;

    typedef logic [31:0] word32_t;

    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] rs_tag_t;

    // Tag value meaning "operand already holds a value" / "CDB idle".
    localparam rs_tag_t NO_VAL = '0;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic    busy;
        logic    dispatched;
        logic    spec;
        logic    killed;
        alu_op_t op;
        word32_t vj;
        rs_tag_t qj;
        word32_t vk;
        rs_tag_t qk;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_prio_select.sv
// rs_prio_select: lowest-index one-hot picker.
// Ports: req (request vector), gnt (one-hot grant), hit (any request).
module rs_prio_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         hit
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign hit = |req;

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds issued instructions until both
// operands arrive on the CDB, then dispatches the lowest-index ready
// entry to the functional unit. Entry i owns tag TAG_BASE+i and is
// freed when that tag appears on the CDB; mispredicts squash spec work.
// Ports: clk_i/reset_i (async, active-high), cdb_i snoop bus,
// issue_* request/allocation, cond_eval_i/corr_pred_i branch resolve,
// fu_* dispatch handshake and payload.
// Optional macro RS_CDB_ISSUE_BYPASS_EN: capture a same-cycle CDB
// result at issue instead of stalling the issue for one cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE    = 1
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  cdb_t    cdb_i,
    input  logic    issue_valid_i,
    output logic    issue_ready_o,
    input  alu_op_t issue_op_i,
    input  logic    issue_spec_i,
    input  word32_t issue_val1_i,
    input  word32_t issue_val2_i,
    input  rs_tag_t issue_tag1_i,
    input  rs_tag_t issue_tag2_i,
    output rs_tag_t issue_tag_o,
    input  logic    cond_eval_i,
    input  logic    corr_pred_i,
    output logic    fu_valid_o,
    input  logic    fu_ready_i,
    output alu_op_t fu_op_o,
    output word32_t fu_a_o,
    output word32_t fu_b_o,
    output rs_tag_t fu_tag_o
);

    function automatic rs_tag_t own_tag(input int i);
        return rs_tag_t'(TAG_BASE + i);
    endfunction

    rs_entry_t ent [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] rdy_vec;
    logic [NUM_ENTRIES-1:0] alloc_sel;
    logic [NUM_ENTRIES-1:0] disp_pick;
    logic [NUM_ENTRIES-1:0] disp_sel;
    logic [NUM_ENTRIES-1:0] hold;
    logic any_free, any_rdy, sel_spec;
    logic mispredict, resolve_ok, issue_block;
    logic issue_fire, disp_fire, cdb_act;
    word32_t new_vj, new_vk;
    rs_tag_t new_qj, new_qk;

    assign cdb_act    = (cdb_i.tag != NO_VAL);
    assign mispredict = cond_eval_i & ~corr_pred_i;
    assign resolve_ok = cond_eval_i & corr_pred_i;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i] = ~ent[i].busy;
            rdy_vec[i]  = ent[i].busy & ~ent[i].dispatched
                        & ~ent[i].killed
                        & (ent[i].qj == NO_VAL)
                        & (ent[i].qk == NO_VAL);
        end
    end

    rs_prio_select #(.N(NUM_ENTRIES)) u_alloc (
        .req (free_vec),
        .gnt (alloc_sel),
        .hit (any_free)
    );

    rs_prio_select #(.N(NUM_ENTRIES)) u_disp (
        .req (rdy_vec),
        .gnt (disp_pick),
        .hit (any_rdy)
    );

    // A stalled offer keeps its entry so fu_* stay stable even if a
    // lower-index entry wakes up meanwhile.
    assign disp_sel = (|(hold & rdy_vec)) ? hold : disp_pick;

`ifdef RS_CDB_ISSUE_BYPASS_EN
    assign issue_block = 1'b0;
    always_comb begin
        new_vj = issue_val1_i;
        new_qj = issue_tag1_i;
        new_vk = issue_val2_i;
        new_qk = issue_tag2_i;
        if (cdb_act && issue_tag1_i == cdb_i.tag) begin
            new_vj = cdb_i.val;
            new_qj = NO_VAL;
        end
        if (cdb_act && issue_tag2_i == cdb_i.tag) begin
            new_vk = cdb_i.val;
            new_qk = NO_VAL;
        end
    end
`else
    // Without the bypass the producer result would be missed, so the
    // issue waits a cycle for the register file to hold it.
    assign issue_block = cdb_act & ((issue_tag1_i == cdb_i.tag)
                                  | (issue_tag2_i == cdb_i.tag));
    assign new_vj = issue_val1_i;
    assign new_qj = issue_tag1_i;
    assign new_vk = issue_val2_i;
    assign new_qk = issue_tag2_i;
`endif

    assign issue_ready_o = any_free & ~mispredict & ~issue_block;
    assign issue_fire    = issue_valid_i & issue_ready_o;

    always_comb begin
        issue_tag_o = NO_VAL;
        fu_op_o     = ALU_ADD;
        fu_a_o      = '0;
        fu_b_o      = '0;
        fu_tag_o    = NO_VAL;
        sel_spec    = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_sel[i]) issue_tag_o = own_tag(i);
            if (disp_sel[i]) begin
                fu_op_o  = ent[i].op;
                fu_a_o   = ent[i].vj;
                fu_b_o   = ent[i].vk;
                fu_tag_o = own_tag(i);
                sel_spec = ent[i].spec;
            end
        end
    end

    assign fu_valid_o = any_rdy & ~(mispredict & sel_spec);
    assign disp_fire  = fu_valid_o & fu_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
            hold <= '0;
        end else begin
            hold <= (fu_valid_o & ~fu_ready_i) ? disp_sel : '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (ent[i].busy) begin
                    if (cdb_act && ent[i].qj == cdb_i.tag) begin
                        ent[i].vj <= cdb_i.val;
                        ent[i].qj <= NO_VAL;
                    end
                    if (cdb_act && ent[i].qk == cdb_i.tag) begin
                        ent[i].vk <= cdb_i.val;
                        ent[i].qk <= NO_VAL;
                    end
                    if (disp_fire && disp_sel[i])
                        ent[i].dispatched <= 1'b1;
                    if (resolve_ok)
                        ent[i].spec <= 1'b0;
                    // In-flight spec work keeps its tag reserved until
                    // the FU result drains off the CDB.
                    if (mispredict && ent[i].spec) begin
                        if (ent[i].dispatched) ent[i].killed <= 1'b1;
                        else                   ent[i] <= '0;
                    end
                    if (cdb_i.tag == own_tag(i))
                        ent[i] <= '0;
                end else if (issue_fire && alloc_sel[i]) begin
                    ent[i] <= '{busy:       1'b1,
                                dispatched: 1'b0,
                                spec:       issue_spec_i,
                                killed:     1'b0,
                                op:         issue_op_i,
                                vj:         new_vj,
                                qj:         new_qj,
                                vk:         new_vk,
                                qk:         new_qk};
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N  = 4;
    localparam int TB = 1;

    logic    clk = 1'b0;
    logic    reset_i = 1'b1;
    cdb_t    cdb_i;
    logic    issue_valid_i, issue_ready_o, issue_spec_i;
    alu_op_t issue_op_i;
    word32_t issue_val1_i, issue_val2_i;
    rs_tag_t issue_tag1_i, issue_tag2_i, issue_tag_o;
    logic    cond_eval_i, corr_pred_i;
    logic    fu_valid_o, fu_ready_i;
    alu_op_t fu_op_o;
    word32_t fu_a_o, fu_b_o;
    rs_tag_t fu_tag_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reservation_station #(.NUM_ENTRIES(N), .TAG_BASE(TB)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .cdb_i         (cdb_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_op_i    (issue_op_i),
        .issue_spec_i  (issue_spec_i),
        .issue_val1_i  (issue_val1_i),
        .issue_val2_i  (issue_val2_i),
        .issue_tag1_i  (issue_tag1_i),
        .issue_tag2_i  (issue_tag2_i),
        .issue_tag_o   (issue_tag_o),
        .cond_eval_i   (cond_eval_i),
        .corr_pred_i   (corr_pred_i),
        .fu_valid_o    (fu_valid_o),
        .fu_ready_i    (fu_ready_i),
        .fu_op_o       (fu_op_o),
        .fu_a_o        (fu_a_o),
        .fu_b_o        (fu_b_o),
        .fu_tag_o      (fu_tag_o)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each slot is an instruction record; operand "present" means
    // its pending tag is NO_VAL.
    bit          m_busy [N];
    bit          m_exec [N];
    bit          m_spec [N];
    bit          m_kill [N];
    logic [2:0]  m_op   [N];
    logic [31:0] m_a    [N];
    logic [31:0] m_b    [N];
    logic [3:0]  m_qa   [N];
    logic [3:0]  m_qb   [N];
    int          m_hold;

    bit e_rdy, e_val;
    int e_tag, e_idx, e_free;

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_exec[i] = 0; m_spec[i] = 0; m_kill[i] = 0;
            m_op[i] = 0; m_a[i] = 0; m_b[i] = 0; m_qa[i] = 0; m_qb[i] = 0;
        end
        m_hold = -1;
    endtask

    function automatic bit m_ready(input int i);
        return m_busy[i] && !m_exec[i] && !m_kill[i]
               && m_qa[i] == 0 && m_qb[i] == 0;
    endfunction

    task automatic m_eval();
        bit mis, blk;
        mis = cond_eval_i && !corr_pred_i;
`ifdef RS_CDB_ISSUE_BYPASS_EN
        blk = 0;
`else
        blk = cdb_i.tag != NO_VAL &&
              (issue_tag1_i == cdb_i.tag || issue_tag2_i == cdb_i.tag);
`endif
        e_free = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) e_free = i;
        e_rdy = e_free >= 0 && !mis && !blk;
        e_tag = e_free >= 0 ? TB + e_free : 0;
        e_idx = -1;
        for (int i = N - 1; i >= 0; i--) if (m_ready(i)) e_idx = i;
        if (m_hold >= 0 && m_ready(m_hold)) e_idx = m_hold;
        e_val = e_idx >= 0 && !(mis && m_spec[e_idx]);
    endtask

    task automatic m_step();
        bit ifire, dfire, mis;
        int fi, di;
        m_eval();
        mis   = cond_eval_i && !corr_pred_i;
        ifire = issue_valid_i && e_rdy;
        dfire = e_val && fu_ready_i;
        fi = e_free;
        di = e_idx;
        for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) continue;
            if (cdb_i.tag != 0 && m_qa[i] == cdb_i.tag) begin
                m_a[i] = cdb_i.val; m_qa[i] = 0;
            end
            if (cdb_i.tag != 0 && m_qb[i] == cdb_i.tag) begin
                m_b[i] = cdb_i.val; m_qb[i] = 0;
            end
            if (dfire && i == di) m_exec[i] = 1;
            if (cond_eval_i && corr_pred_i) m_spec[i] = 0;
            if (mis && m_spec[i]) begin
                if (m_exec[i]) m_kill[i] = 1;
                else m_busy[i] = 0;
            end
            if (int'(cdb_i.tag) == TB + i) m_busy[i] = 0;
            if (!m_busy[i]) begin
                m_exec[i] = 0; m_spec[i] = 0; m_kill[i] = 0;
            end
        end
        if (ifire) begin
            m_busy[fi] = 1; m_exec[fi] = 0; m_kill[fi] = 0;
            m_spec[fi] = issue_spec_i;
            m_op[fi] = issue_op_i;
            m_a[fi] = issue_val1_i; m_qa[fi] = issue_tag1_i;
            m_b[fi] = issue_val2_i; m_qb[fi] = issue_tag2_i;
`ifdef RS_CDB_ISSUE_BYPASS_EN
            if (cdb_i.tag != 0 && issue_tag1_i == cdb_i.tag) begin
                m_a[fi] = cdb_i.val; m_qa[fi] = 0;
            end
            if (cdb_i.tag != 0 && issue_tag2_i == cdb_i.tag) begin
                m_b[fi] = cdb_i.val; m_qb[fi] = 0;
            end
`endif
        end
        m_hold = (e_val && !fu_ready_i) ? di : -1;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge reset_i);
            if (reset_i) m_clear();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            m_eval();
            chk("m_issue_ready", issue_ready_o, e_rdy);
            chk("m_issue_tag", issue_tag_o, e_tag);
            chk("m_fu_valid", fu_valid_o, e_val);
            if (e_val) begin
                chk("m_fu_op", fu_op_o, m_op[e_idx]);
                chk("m_fu_a", fu_a_o, m_a[e_idx]);
                chk("m_fu_b", fu_b_o, m_b[e_idx]);
                chk("m_fu_tag", fu_tag_o, TB + e_idx);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        issue_valid_i = 0; issue_op_i = ALU_ADD; issue_spec_i = 0;
        issue_val1_i = 0; issue_val2_i = 0;
        issue_tag1_i = NO_VAL; issue_tag2_i = NO_VAL;
        cdb_i = '{tag: NO_VAL, val: 32'h0};
        cond_eval_i = 0; corr_pred_i = 0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    task automatic iss(input alu_op_t op, input logic sp,
                       input word32_t v1, input rs_tag_t t1,
                       input word32_t v2, input rs_tag_t t2);
        issue_valid_i = 1; issue_op_i = op; issue_spec_i = sp;
        issue_val1_i = v1; issue_tag1_i = t1;
        issue_val2_i = v2; issue_tag2_i = t2;
    endtask

    task automatic bus(input rs_tag_t t, input word32_t v);
        cdb_i = '{tag: t, val: v};
    endtask

    initial begin
        idle();
        fu_ready_i = 1;
        // reset state
        @(negedge clk); #3;
        chk("rst_ready", issue_ready_o, 1);
        chk("rst_tag", issue_tag_o, 1);
        chk("rst_valid", fu_valid_o, 0);
        chk("rst_op", fu_op_o, 0);
        chk("rst_a", fu_a_o, 0);
        chk("rst_b", fu_b_o, 0);
        chk("rst_fu_tag", fu_tag_o, 0);

        // basic issue -> dispatch -> free
        nxt(); reset_i = 0; iss(ALU_ADD, 0, 5, 0, 7, 0);
        #3 chk("t1_tag", issue_tag_o, 1);
        nxt(); #3;
        chk("t1_valid", fu_valid_o, 1);
        chk("t1_a", fu_a_o, 5);
        chk("t1_b", fu_b_o, 7);
        chk("t1_fu_tag", fu_tag_o, 1);
        nxt(); #3 chk("t1_busy_tag", issue_tag_o, 2);
        nxt(); bus(1, 32'd12);
        nxt(); #3 chk("t1_freed", issue_tag_o, 1);

        // wake-up from CDB
        nxt(); iss(ALU_SUB, 0, 0, 3, 9, 0);
        nxt(); #3 chk("t2_wait", fu_valid_o, 0);
        nxt(); bus(3, 32'hDEAD);
        #3 chk("t2_wait2", fu_valid_o, 0);
        nxt(); #3;
        chk("t2_valid", fu_valid_o, 1);
        chk("t2_a", fu_a_o, 32'hDEAD);
        chk("t2_b", fu_b_o, 9);
        chk("t2_op", fu_op_o, ALU_SUB);
        nxt(); bus(1, 0);
        nxt();

        // issue with a same-cycle CDB producer
`ifdef RS_CDB_ISSUE_BYPASS_EN
        nxt(); iss(ALU_AND, 0, 0, 3, 1, 0); bus(3, 32'h42);
        #3 chk("t3_ready", issue_ready_o, 1);
`else
        nxt(); iss(ALU_AND, 0, 0, 3, 1, 0); bus(3, 32'h42);
        #3 chk("t3_blocked", issue_ready_o, 0);
        nxt(); iss(ALU_AND, 0, 32'h42, 0, 1, 0);
`endif
        nxt(); #3;
        chk("t3_valid", fu_valid_o, 1);
        chk("t3_a", fu_a_o, 32'h42);
        nxt(); bus(1, 0);
        nxt();

        // fill all entries
        for (int k = 0; k < N; k++) begin
            nxt(); iss(ALU_XOR, 0, k + 1, 0, k + 10, 0);
        end
        nxt(); iss(ALU_OR, 0, 99, 0, 98, 0);
        #3;
        chk("t4_full_ready", issue_ready_o, 0);
        chk("t4_full_tag", issue_tag_o, 0);
        nxt(); #3 chk("t4_full_ready2", issue_ready_o, 0);
        nxt(); bus(2, 0);
        nxt(); #3 chk("t4_tag2", issue_tag_o, 2);
        nxt(); bus(1, 0);
        nxt(); bus(3, 0);
        nxt(); bus(4, 0);
        nxt(); #3 chk("t4_empty", issue_tag_o, 1);

        // mispredict: dispatched spec killed, waiting spec freed
        nxt(); iss(ALU_ADD, 1, 1, 0, 2, 0);
        nxt(); iss(ALU_ADD, 1, 0, 7, 3, 0);
        #3 chk("t5_disp_tag", fu_tag_o, 1);
        nxt(); #3 chk("t5_idle", fu_valid_o, 0);
        nxt(); cond_eval_i = 1; corr_pred_i = 0;
        #3 chk("t5_mis_ready", issue_ready_o, 0);
        nxt(); #3 chk("t5_tag2_free", issue_tag_o, 2);
        nxt(); bus(7, 32'h5);
        nxt(); #3 chk("t5_no_wake", fu_valid_o, 0);
        nxt(); bus(1, 0);
        nxt(); #3 chk("t5_tag1_free", issue_tag_o, 1);

        // correct resolve clears spec; mispredict drops pending spec
        fu_ready_i = 0;
        nxt(); iss(ALU_OR, 1, 32'hA, 0, 32'hB, 0);
        nxt(); #3 chk("t5b_stall", fu_valid_o, 1);
        nxt(); cond_eval_i = 1; corr_pred_i = 1;
        #3 chk("t5b_ok_valid", fu_valid_o, 1);
        nxt(); cond_eval_i = 1; corr_pred_i = 0;
        #3 chk("t5b_nonspec", fu_valid_o, 1);
        nxt(); fu_ready_i = 1;
        nxt(); bus(1, 0);
        fu_ready_i = 0;
        nxt(); iss(ALU_SLL, 1, 32'h3, 0, 32'h1, 0);
        nxt(); #3 chk("t5c_pend", fu_valid_o, 1);
        nxt(); cond_eval_i = 1; corr_pred_i = 0;
        #3 chk("t5c_drop", fu_valid_o, 0);
        nxt(); #3 chk("t5c_freed", issue_tag_o, 1);

        // stall hold, then reset mid-stall
        nxt(); iss(ALU_SUB, 0, 0, 7, 5, 0);
        nxt(); iss(ALU_OR, 0, 32'h11, 0, 32'h22, 0);
        for (int s = 0; s < 3; s++) begin
            nxt();
            if (s == 1) bus(7, 32'h99);
            #3;
            chk("t6_valid", fu_valid_o, 1);
            chk("t6_tag", fu_tag_o, 2);
            chk("t6_a", fu_a_o, 32'h11);
            chk("t6_b", fu_b_o, 32'h22);
            chk("t6_op", fu_op_o, ALU_OR);
        end
        nxt(); #1 reset_i = 1;
        #1;
        chk("t6_rst_valid", fu_valid_o, 0);
        chk("t6_rst_tag", issue_tag_o, 1);
        nxt(); reset_i = 0; fu_ready_i = 1;
        #3 chk("t6_no_replay", fu_valid_o, 0);
        nxt(); #3 chk("t6_no_replay2", fu_valid_o, 0);
        nxt(); #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Tomasulo reservation station between the issue logic/register file and one functional unit. Accepts an issued instruction with operands as either a value or a producer tag. Snoops the common data bus until both operands are present, then dispatches the oldest-index ready entry to the FU. Entries are named by tags, which the register file records as `wr_tag_i`. An entry is freed when its own tag is broadcast on the CDB; speculative entries are squashed on a branch mispredict.

## Interface
- `NUM_ENTRIES`, 4: entry count, 1..8.
- `TAG_BASE`, 1: tag of entry 0; entry i owns tag `TAG_BASE+i`, none may equal `NO_VAL`.
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `cdb_i` in `cdb_t`: result broadcast {tag, val}; `tag==NO_VAL` means idle.
- `issue_valid_i` in 1: issue request.
- `issue_ready_o` out 1: an entry can accept this cycle.
- `issue_op_i` in `alu_op_t`: operation.
- `issue_spec_i` in 1: instruction issued under an unresolved branch.
- `issue_val1_i`, `issue_val2_i` in 32: operand values (`word32_t`).
- `issue_tag1_i`, `issue_tag2_i` in `rs_tag_t`: producer tags; `NO_VAL` means the value is valid.
- `issue_tag_o` out `rs_tag_t`: tag of the entry that will be allocated; `NO_VAL` when full.
- `cond_eval_i`, `corr_pred_i` in 1: branch resolved / prediction correct.
- `fu_valid_o` out 1, `fu_ready_i` in 1: dispatch handshake.
- `fu_op_o` out `alu_op_t`, `fu_a_o`/`fu_b_o` out 32, `fu_tag_o` out `rs_tag_t`: dispatched instruction.

## Operation
- Entry state: busy, dispatched, spec, killed, op, Vj/Qj, Vk/Qk.
- Entry states: FREE → WAIT (some Q≠NO_VAL) → READY (both Q==NO_VAL) → EXEC (dispatched) → FREE when `cdb_i.tag` equals its own tag.
- Allocation: lowest-index FREE entry. `issue_ready_o` = any FREE entry & ~(`cond_eval_i & ~corr_pred_i`). Issue fires on `issue_valid_i & issue_ready_o`.
- Issue CDB bypass: if `issue_tagN_i == cdb_i.tag` and the tag is not `NO_VAL`, store `cdb_i.val` with `QN=NO_VAL`.
- Wake-up: every busy entry with `Qj` or `Qk == cdb_i.tag` (tag not `NO_VAL`) captures the value and clears the Q.
- Dispatch: lowest-index READY entry, not killed. `fu_*` are combinational from entry storage. On `fu_valid_o & fu_ready_i` the entry is marked dispatched at the edge. `fu_*` must hold stable while valid & ~ready, unless squashed.
- Resolve correct (`cond_eval_i & corr_pred_i`): clear spec on all entries.
- Resolve mispredict (`cond_eval_i & ~corr_pred_i`):
  - Spec entries that are not dispatched become FREE.
  - Spec entries that are dispatched become killed. They stay busy until their own tag appears on the CDB, so the tag is not reused while the FU is in flight.
- Only one unresolved branch exists at a time.

## Timing
- Reset (async): all entries FREE, all flags 0.
  - `issue_ready_o`=1, `issue_tag_o`=`TAG_BASE`, `fu_valid_o`=0, `fu_op_o`/`fu_a_o`/`fu_b_o`=0, `fu_tag_o`=`NO_VAL`.
  - Reset mid-dispatch drops everything; nothing is replayed.
- Issue-to-dispatch latency: 1 cycle minimum. An entry written at edge N can have `fu_valid_o` in cycle N+1.
- Wake-up latency: a CDB capture at edge N makes the entry dispatchable in cycle N+1.
- Free: own tag on the CDB at edge N → `issue_ready_o` may assert in cycle N+1. There is no same-cycle reuse.
- Full: `issue_ready_o`=0 and `issue_tag_o`=`NO_VAL`. An `issue_valid_i` while full is ignored.
- Mispredict cycle: issue is blocked, and a pending dispatch of a spec entry is dropped (`fu_valid_o` forced 0).

## Configuration
- `RS_CDB_ISSUE_BYPASS_EN` defined: issue-time CDB bypass as described above.
- Undefined: no bypass. `issue_ready_o` is deasserted in any cycle where a non-`NO_VAL` `cdb_i.tag` equals `issue_tag1_i` or `issue_tag2_i`. Issue retries next cycle, when the register file already holds the value.

## Structure
- Shared package holds `word32_t`, `rs_tag_t`, `NO_VAL`, `cdb_t`, `alu_op_t`, plus a new `rs_entry_t` struct.
- Sub-module `rs_prio_select`: parameterised lowest-index one-hot picker, instantiated for allocation and for dispatch.

## Test plan
- Issue op ADD, val1=5, val2=7, both tags `NO_VAL`, with `fu_ready_i`=1 → next cycle `fu_valid_o`=1, `fu_a_o`=5, `fu_b_o`=7, `fu_tag_o`=1. CDB tag 1 two cycles later frees the entry.
- Issue with tag1=3 (external). CDB {3, 0xDEAD} two cycles later → entry dispatches the following cycle with `fu_a_o`=0xDEAD.
- Issue with tag1=3 while CDB carries {3, 0x42} in the same cycle → bypass build dispatches `fu_a_o`=0x42. Non-bypass build shows `issue_ready_o`=0 in that cycle.
- Fill 4 entries → `issue_ready_o`=0, `issue_tag_o`=`NO_VAL`. CDB tag 2 → next cycle `issue_tag_o`=2.
- Two spec entries, one dispatched (tag 1), one waiting (tag 2), then mispredict → tag 2 is FREE next cycle, tag 1 stays busy until CDB tag 1.
- `fu_ready_i`=0 for 3 cycles with an entry ready → `fu_*` held stable. Assert `reset_i` mid-stall → `fu_valid_o`=0 immediately.
